run_sequencer: RTL and testbench

Parametrised run-control sequencer for the 9-bit-instruction processor top level. It replaces the ad-hoc start/ack logic and the free-running cycle counter. It owns the start/ack handshake with the testbench and selects one of several program entry points. It gates instruction issue (NOP substitution), counts cycles per run, and raises a watchdog timeout. It sits between the test harness and the program counter and control decoder.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/sat_counter.sv | 36 +++
 rtl/run_sequencer.sv | 118 +++++++++++
 tb/tb_run_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 9-bit-instruction processor run-control path.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        LOAD,
        RUN,
        DONE
    } run_state_t;

    localparam logic [8:0] NOP_INSTR          = 9'b100000000;
    localparam int         RUN_MAX_CYCLES_DEF = 4096;
    localparam int         PROG_STRIDE_DEF    = 64;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that clears on clr, steps on inc, and holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign at_max = &count_q;
    assign count  = count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !at_max) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Run-control sequencer: start/ack handshake, entry-point select, issue gating and cycle count.
// Optional watchdog timeout is enabled by defining RUN_SEQ_WATCHDOG_EN.
module run_sequencer
    import cpu_pkg::*;
#(
    parameter  int NUM_PROGS   = 4,
    parameter  int PROG_STRIDE = PROG_STRIDE_DEF,
    parameter  int PC_W        = 32,
    parameter  int CYC_W       = 16,
    parameter  int MAX_CYCLES  = RUN_MAX_CYCLES_DEF,
    localparam int SEL_W       = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEL_W-1:0] prog_sel,
    input  logic             done_in,
    output logic             run_en,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_load_val,
    output logic             ack,
    output logic             timeout,
    output logic             busy,
    output logic [CYC_W-1:0] cycle_count
);

    run_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             timeout_q, timeout_d;
    logic [SEL_W-1:0] sel_clamped;
    logic             cnt_clr, cnt_inc, cnt_max;
    logic             wd_hit;

    // Out-of-range program indices fall back to entry point 0.
    assign sel_clamped = (32'(prog_sel) >= NUM_PROGS) ? '0 : prog_sel;

`ifdef RUN_SEQ_WATCHDOG_EN
    assign wd_hit = (cycle_count == CYC_W'(MAX_CYCLES - 1));
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        timeout_d = timeout_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARMED;
                    sel_d   = sel_clamped;
                end
            end
            ARMED: begin
                if (!start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_clr = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                cnt_inc = !cnt_max;
                // done_in takes priority over a watchdog hit on the same edge.
                if (done_in) begin
                    state_d   = DONE;
                    timeout_d = 1'b0;
                end else if (wd_hit) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = ARMED;
                    sel_d     = sel_clamped;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(
        .WIDTH(CYC_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (cycle_count),
        .at_max(cnt_max)
    );

    // Every output decodes from registered state only.
    assign run_en      = (state_q == RUN);
    assign pc_load     = (state_q == LOAD);
    assign busy        = (state_q == LOAD) || (state_q == RUN);
    assign ack         = (state_q == DONE);
    assign timeout     = timeout_q;
    assign pc_load_val = PC_W'(sel_q) * PC_W'(PROG_STRIDE);

endmodule

// File: tb/tb_run_sequencer.sv
// Randomized self-checking bench for run_sequencer against a run-level reference model.
`timescale 1ns/1ps
module tb_run_sequencer;

    localparam int NUM_PROGS   = 3;
    localparam int PROG_STRIDE = 64;
    localparam int PC_W        = 32;
    localparam int MAX_CYC     = 16;
`ifdef RUN_SEQ_WATCHDOG_EN
    localparam int CYC_W = 8;
    localparam bit WD    = 1'b1;
`else
    localparam int CYC_W = 4;
    localparam bit WD    = 1'b0;
`endif
    localparam int SAT   = (1 << CYC_W) - 1;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [SEL_W-1:0] prog_sel = '0;
    logic             done_in = 1'b0;
    logic             run_en, pc_load, ack, timeout, busy;
    logic [PC_W-1:0]  pc_load_val;
    logic [CYC_W-1:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    run_sequencer #(
        .NUM_PROGS  (NUM_PROGS),
        .PROG_STRIDE(PROG_STRIDE),
        .PC_W       (PC_W),
        .CYC_W      (CYC_W),
        .MAX_CYCLES (MAX_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .prog_sel   (prog_sel),
        .done_in    (done_in),
        .run_en     (run_en),
        .pc_load    (pc_load),
        .pc_load_val(pc_load_val),
        .ack        (ack),
        .timeout    (timeout),
        .busy       (busy),
        .cycle_count(cycle_count)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_run_en"}, run_en, 0);
        check({tag, "_pc_load"}, pc_load, 0);
        check({tag, "_pc_val"}, pc_load_val, 0);
        check({tag, "_ack"}, ack, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_count"}, cycle_count, 0);
    endtask

    // done_at: run cycle (1-based) with done_in=1, 0 = never. abort_at: run cycle to pull reset, 0 = never.
    task automatic do_run(input int sel, input int done_at, input int abort_at, input bit toggle);
        int  exp_pc;
        int  n;
        bit  ending;
        bit  fin;
        int  end_cnt;
        bit  end_to;
        exp_pc   = ((sel < NUM_PROGS) ? sel : 0) * PROG_STRIDE;
        prog_sel = SEL_W'(sel);
        start    = 1'b1;
        done_in  = 1'b0;
        tick();
        check("armed_ack", ack, 0);
        check("armed_timeout", timeout, 0);
        check("armed_busy", busy, 0);
        tick();
        tick();
        start    = 1'b0;
        prog_sel = SEL_W'($urandom_range(0, 3));
        tick();
        check("load_pc_load", pc_load, 1);
        check("load_pc_val", pc_load_val, exp_pc);
        check("load_run_en", run_en, 0);
        check("load_busy", busy, 1);
        tick();
        check("run1_pc_load", pc_load, 0);
        n   = 1;
        fin = 1'b0;
        while (!fin) begin
            check("run_en", run_en, 1);
            check("run_count", cycle_count, sat(n - 1));
            check("run_ack", ack, 0);
            check("run_timeout", timeout, 0);
            if (abort_at != 0 && n == abort_at) begin
                reset = 1'b0;
                start = 1'b0;
                tick();
                reset = 1'b1;
                check_all_zero("abort");
                fin = 1'b1;
            end else begin
                ending  = (n == done_at) || (WD && n == MAX_CYC);
                done_in = (n == done_at);
                start   = (!ending && toggle) ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
                done_in = 1'b0;
                start   = 1'b0;
                if (ending) begin
                    end_cnt = sat(n);
                    end_to  = (n != done_at);
                    check("end_ack", ack, 1);
                    check("end_run_en", run_en, 0);
                    check("end_busy", busy, 0);
                    check("end_timeout", timeout, end_to);
                    check("end_count", cycle_count, end_cnt);
                    for (int k = 0; k < 2; k++) begin
                        done_in = 1'($urandom_range(0, 1));
                        tick();
                        check("hold_ack", ack, 1);
                        check("hold_timeout", timeout, end_to);
                        check("hold_count", cycle_count, end_cnt);
                    end
                    done_in = 1'b0;
                    fin     = 1'b1;
                end else begin
                    n++;
                    if (n > 64) begin
                        check("run_bound", n, 64);
                        fin = 1'b1;
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        check_all_zero("idle");

        do_run(2, 10, 0, 1'b0);
        if (WD) begin
            do_run(1, 0, 0, 1'b0);
            do_run(0, 16, 0, 1'b0);
        end else begin
            do_run(1, 0, 21, 1'b0);
            do_run(0, 17, 0, 1'b0);
        end
        do_run(3, 0, 7, 1'b1);
        do_run(1, 1, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            do_run(int'($urandom_range(0, 3)), int'($urandom_range(1, 22)), 0,
                   1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench time limit reached");
    end

endmodule
